// File: rtl/wb_slave_pkg.sv
// -----------------------------------------------------------------------------
// wb_slave_pkg
// Shared types and constants for the Wishbone register slave (wb_reg_slave)
// and its register bank (wb_reg_bank).
//   DATA_W       : bus / register data width
//   ID_VALUE_DEF : default constant returned by register 0
//   WAIT_CNT_W   : width of the wait-state down-counter (covers 0..15)
//   state_e      : bus-handshake FSM states
// -----------------------------------------------------------------------------
package wb_slave_pkg;

    localparam int                DATA_W       = 32;
    localparam logic [DATA_W-1:0] ID_VALUE_DEF = 32'hCAFE_0001;
    localparam int                WAIT_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/wb_reg_bank.sv
// -----------------------------------------------------------------------------
// wb_reg_bank
// Register storage behind the Wishbone slave.
//   reg 0         : read-only ID constant
//   reg 1..NREGS-2: 32-bit read/write
//   reg NREGS-1   : read-only transaction counter
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en_i   : commit wdata_i into register idx_i (ignored for read-only regs)
//   inc_i     : bump the transaction counter
//   idx_i     : register index for both write and read
//   wdata_i   : write data
//   rdata_o   : combinational read of register idx_i
//   regs_o    : flattened contents, reg k at [32k +: 32]
// -----------------------------------------------------------------------------
module wb_reg_bank
    import wb_slave_pkg::*;
#(
    parameter int                NREGS    = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic                          inc_i,
    input  logic [$clog2(NREGS)-1:0]      idx_i,
    input  logic [DATA_W-1:0]             wdata_i,
    output logic [DATA_W-1:0]             rdata_o,
    output logic [NREGS*DATA_W-1:0]       regs_o
);

    localparam int IDX_W = $clog2(NREGS);

    // Only the R/W registers are stored; reg 0 and the counter live elsewhere.
    logic [DATA_W-1:0] regs_q [1:NREGS-2];
    logic [DATA_W-1:0] cnt_q;

    // NOTE: every register is reset here, because software reads back zeros after
    // reset; a bank without that guarantee could drop the reset and map to RAM.
    // NOTE: state is written with non-blocking assignments so all flops update
    // together at the edge, whatever order the statements are in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= NREGS-2; k++) begin
                regs_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            if (wr_en_i) begin
                for (int k = 1; k <= NREGS-2; k++) begin
                    if (idx_i == IDX_W'(k)) begin
                        regs_q[k] <= wdata_i;
                    end
                end
            end
            if (inc_i) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the output gets a default before any branch, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rdata_o = '0;
        if (idx_i == '0) begin
            rdata_o = ID_VALUE;
        end else if (idx_i == IDX_W'(NREGS-1)) begin
            rdata_o = cnt_q;
        end else begin
            for (int k = 1; k <= NREGS-2; k++) begin
                if (idx_i == IDX_W'(k)) begin
                    rdata_o = regs_q[k];
                end
            end
        end
    end

    assign regs_o[0 +: DATA_W] = ID_VALUE;
    for (genvar g = 1; g <= NREGS-2; g++) begin : g_regs_out
        assign regs_o[g*DATA_W +: DATA_W] = regs_q[g];
    end
    assign regs_o[(NREGS-1)*DATA_W +: DATA_W] = cnt_q;

endmodule

// File: rtl/wb_reg_slave.sv
// -----------------------------------------------------------------------------
// wb_reg_slave
// Wishbone slave with NREGS 32-bit registers and a configurable number of
// wait states. Handshake FSM: IDLE (accepting) -> WAIT (optional) -> ACK.
// Writes commit and read data is captured on the edge entering ACK; dropping
// i_wb_cyc during WAIT abandons the transfer without side effects.
// Optional build macro WB_SLAVE_ERR_EN: adds o_wb_err, raised instead of
// o_wb_ack for out-of-range addresses.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   i_wb_cyc, i_wb_stb   : cycle / strobe from master
//   i_wb_we              : 1 = write, 0 = read
//   i_wb_addr            : byte address, bits [1:0] don't care
//   i_wb_data            : write data
//   o_wb_data            : read data, valid only while o_wb_ack is high
//   o_wb_stall           : high whenever a transfer is in progress
//   o_wb_ack             : one-cycle completion
//   o_regs               : flattened register contents
//   o_wb_err             : (WB_SLAVE_ERR_EN only) out-of-range completion
// -----------------------------------------------------------------------------
module wb_reg_slave
    import wb_slave_pkg::*;
#(
    parameter int                NREGS       = 16,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] ID_VALUE    = ID_VALUE_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_wb_cyc,
    input  logic                    i_wb_stb,
    input  logic                    i_wb_we,
    input  logic [31:0]             i_wb_addr,
    input  logic [DATA_W-1:0]       i_wb_data,
    output logic [DATA_W-1:0]       o_wb_data,
    output logic                    o_wb_stall,
    output logic                    o_wb_ack,
    output logic [NREGS*DATA_W-1:0] o_regs
`ifdef WB_SLAVE_ERR_EN
    ,
    output logic                    o_wb_err
`endif
);

    localparam int                    IDX_W       = $clog2(NREGS);
    localparam int                    WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD   = WAIT_CNT_W'(WAIT_LOAD_I);

    state_e                  state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wcnt_q, wcnt_d;
    logic [31:2]             addr_q;
    logic                    we_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W-1:0]       rdata_q, rdata_d;

    logic                    accept;
    logic                    enter_ack;
    logic                    oor_block;
    logic [31:2]             req_addr;
    logic                    req_we;
    logic [DATA_W-1:0]       req_wdata;
    logic [IDX_W-1:0]        req_idx;
    logic                    in_range;
    logic [DATA_W-1:0]       bank_rdata;

    // Byte-lane bits carry no meaning for word registers.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_wb_addr[1:0];

    assign accept = (state_q == ST_IDLE) && i_wb_cyc && i_wb_stb;

    // With zero wait states the commit edge is the accept edge, so the live bus
    // fields are used in IDLE and the latched copies afterwards.
    assign req_addr  = (state_q == ST_IDLE) ? i_wb_addr[31:2] : addr_q;
    assign req_we    = (state_q == ST_IDLE) ? i_wb_we         : we_q;
    assign req_wdata = (state_q == ST_IDLE) ? i_wb_data       : wdata_q;
    assign req_idx   = req_addr[2 +: IDX_W];
    assign in_range  = (req_addr[31:2+IDX_W] == '0);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q == '0) begin
                    state_d = ST_ACK;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);

`ifdef WB_SLAVE_ERR_EN
    // Out-of-range transfers complete with err and leave all state untouched.
    assign oor_block = !in_range;
`else
    assign oor_block = 1'b0;
`endif

    // Read data only during the ACK cycle; zero otherwise and for writes.
    assign rdata_d = (enter_ack && !req_we && in_range && !oor_block) ? bank_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            rdata_q <= rdata_d;
            if (accept) begin
                addr_q  <= i_wb_addr[31:2];
                we_q    <= i_wb_we;
                wdata_q <= i_wb_data;
            end
        end
    end

`ifdef WB_SLAVE_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (enter_ack) begin
            err_q <= !in_range;
        end
    end

    assign o_wb_ack = (state_q == ST_ACK) && !err_q;
    assign o_wb_err = (state_q == ST_ACK) && err_q;
`else
    assign o_wb_ack = (state_q == ST_ACK);
`endif

    assign o_wb_stall = (state_q != ST_IDLE);
    assign o_wb_data  = rdata_q;

    wb_reg_bank #(
        .NREGS    (NREGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (enter_ack && !oor_block && req_we && in_range),
        .inc_i   (enter_ack && !oor_block),
        .idx_i   (req_idx),
        .wdata_i (req_wdata),
        .rdata_o (bank_rdata),
        .regs_o  (o_regs)
    );

endmodule

// File: tb/tb_wb_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_reg_slave
// Three wb_reg_slave instances (NREGS=16) with WAIT_CYCLES = 1, 3 and 0 share
// one clock and reset. Each transfer pushes its expected completion onto a
// queue; the entry is popped and compared when ack/err appears.
// -----------------------------------------------------------------------------
module tb_wb_reg_slave;

`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst;

    logic          cyc_s   [3];
    logic          stb_s   [3];
    logic          we_s    [3];
    logic [31:0]   addr_s  [3];
    logic [31:0]   wdat_s  [3];
    logic [31:0]   rdat_s  [3];
    logic          stall_s [3];
    logic          ack_s   [3];
    logic          err_s   [3];
    logic [NR*32-1:0] regs_s [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wb_reg_slave #(
            .NREGS       (NR),
            .WAIT_CYCLES ((g == 0) ? 1 : ((g == 1) ? 3 : 0))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .i_wb_cyc   (cyc_s[g]),
            .i_wb_stb   (stb_s[g]),
            .i_wb_we    (we_s[g]),
            .i_wb_addr  (addr_s[g]),
            .i_wb_data  (wdat_s[g]),
            .o_wb_data  (rdat_s[g]),
            .o_wb_stall (stall_s[g]),
            .o_wb_ack   (ack_s[g]),
            .o_regs     (regs_s[g])
`ifdef WB_SLAVE_ERR_EN
            ,
            .o_wb_err   (err_s[g])
`endif
        );
`ifndef WB_SLAVE_ERR_EN
        assign err_s[g] = 1'b0;
`endif
    end

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          rd;
        int          lat;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          oor;
    } vec_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int d, input int k);
        logic [NR*32-1:0] r;
        r = regs_s[d];
        return r[k*32 +: 32];
    endfunction

    // One complete transfer on instance d; expectation queued at drive time.
    task automatic do_txn(input int d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input bit exp_err, input int exp_lat, input string name);
        exp_t e;
        bit   got;
        int   lat;
        sb.push_back('{data: exp_data, err: exp_err, rd: !we, lat: exp_lat});
        @(negedge clk);
        cyc_s[d]  = 1'b1;
        stb_s[d]  = 1'b1;
        we_s[d]   = we;
        addr_s[d] = addr;
        wdat_s[d] = wdata;
        @(posedge clk);
        #1 stb_s[d] = 1'b0;
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20 && !got; n++) begin
            @(negedge clk);
            if (ack_s[d] || err_s[d]) begin
                got = 1'b1;
                lat = n;
            end
        end
        e = sb.pop_front();
        if (!got) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_lat"}, 32'(lat), 32'(e.lat));
            check({name, "_err"}, 32'(err_s[d]), 32'(e.err));
            check({name, "_ack"}, 32'(ack_s[d]), 32'(!e.err));
            if (e.rd && !e.err) check({name, "_data"}, rdat_s[d], e.data);
        end
        cyc_s[d] = 1'b0;
    endtask

    vec_t vecs [15];

    initial begin
        int acks;
        int bad;
        bit got;
        int lat;

        vecs[0]  = '{1'b1, 32'h04, 32'h1234_5678, 32'h0,         1'b0};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,         32'h1234_5678, 1'b0};
        vecs[2]  = '{1'b1, 32'h00, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 32'h00, 32'h0,         32'hCAFE_0001, 1'b0};
        vecs[4]  = '{1'b0, 32'h3C, 32'h0,         32'd4,         1'b0};
        vecs[5]  = '{1'b1, 32'h3C, 32'hDEAD_BEEF, 32'h0,         1'b0};
        vecs[6]  = '{1'b0, 32'h3C, 32'h0,         32'd6,         1'b0};
        vecs[7]  = '{1'b1, 32'h08, 32'hA5A5_5A5A, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 32'h08, 32'h0,         32'hA5A5_5A5A, 1'b0};
        vecs[9]  = '{1'b1, 32'h38, 32'hFFFF_FFFF, 32'h0,         1'b0};
        vecs[10] = '{1'b0, 32'h38, 32'h0,         32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{1'b0, 32'h40, 32'h0,         32'h0,         1'b1};
        vecs[12] = '{1'b1, 32'h44, 32'h1111_1111, 32'h0,         1'b1};
        vecs[13] = '{1'b0, 32'h04, 32'h0,         32'h1234_5678, 1'b0};
        vecs[14] = '{1'b0, 32'h07, 32'h0,         32'h1234_5678, 1'b0};

        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            cyc_s[d] = 1'b0; stb_s[d] = 1'b0; we_s[d] = 1'b0;
            addr_s[d] = '0;  wdat_s[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_ack",   32'(ack_s[d]),   32'd0);
            check("reset_stall", 32'(stall_s[d]), 32'd0);
            check("reset_data",  rdat_s[d],       32'd0);
            check("reset_cnt",   reg_of(d, NR-1), 32'd0);
        end
        rst = 1'b0;

        // Instance 0, one wait state: table of transfers.
        for (int i = 0; i < 15; i++) begin
            do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
                   vecs[i].oor && ERR_EN, 2, $sformatf("vec%0d", i));
            if (i == 1) check("w1_cnt_after_rw", reg_of(0, NR-1), 32'd2);
        end
        @(negedge clk);
        check("w1_data_idle",  rdat_s[0],       32'd0);
        check("w1_reg1",       reg_of(0, 1),    32'h1234_5678);
        check("w1_reg2",       reg_of(0, 2),    32'hA5A5_5A5A);
        check("w1_reg14",      reg_of(0, 14),   32'hFFFF_FFFF);
        check("w1_reg0",       reg_of(0, 0),    32'hCAFE_0001);
        check("w1_cnt_final",  reg_of(0, NR-1), ERR_EN ? 32'd13 : 32'd15);

        // Instance 1, three wait states: abort two cycles after accept.
        @(negedge clk);
        cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
        addr_s[1] = 32'h08; wdat_s[1] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 stb_s[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cyc_s[1] = 1'b0;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack_s[1]) acks++;
        end
        check("abort_no_ack", 32'(acks),       32'd0);
        check("abort_reg2",   reg_of(1, 2),    32'd0);
        check("abort_cnt",    reg_of(1, NR-1), 32'd0);

        do_txn(1, 1'b1, 32'h10, 32'h0BAD_F00D, 32'h0, 1'b0, 4, "w3_write");
        @(negedge clk);
        check("w3_reg4", reg_of(1, 4),    32'h0BAD_F00D);
        check("w3_cnt",  reg_of(1, NR-1), 32'd1);

        // Strobe while stalled must be dropped, not queued.
        @(negedge clk);
        cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b0; addr_s[1] = 32'h10;
        @(posedge clk);
        #1 we_s[1] = 1'b1; addr_s[1] = 32'h14; wdat_s[1] = 32'h7777_7777;
        @(negedge clk);
        @(negedge clk);
        stb_s[1] = 1'b0;
        got = 1'b0;
        lat = 2;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = ack_s[1];
        end
        check("stall_read_lat",  32'(lat),  32'd4);
        check("stall_read_data", rdat_s[1], 32'h0BAD_F00D);
        acks = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (ack_s[1]) acks++;
        end
        check("stall_not_queued", 32'(acks),    32'd0);
        check("stall_reg5",       reg_of(1, 5), 32'd0);
        cyc_s[1] = 1'b0;

        // Instance 2, zero wait states: back-to-back strobes.
        @(negedge clk);
        cyc_s[2] = 1'b1; stb_s[2] = 1'b1; we_s[2] = 1'b0; addr_s[2] = 32'h04;
        acks = 0;
        bad  = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack_s[2]) acks++;
            if (stall_s[2] !== ack_s[2]) bad++;
        end
        cyc_s[2] = 1'b0; stb_s[2] = 1'b0;
        check("b2b_acks",      32'(acks), 32'd4);
        check("b2b_stall_ack", 32'(bad),  32'd0);
        @(negedge clk);
        check("b2b_cnt", reg_of(2, NR-1), 32'd4);
        do_txn(2, 1'b1, 32'h0C, 32'h5555_AAAA, 32'h0, 1'b0, 1, "w0_write");

        // Reset in the middle of a wait on instance 1.
        @(negedge clk);
        cyc_s[1] = 1'b1; stb_s[1] = 1'b1; we_s[1] = 1'b1;
        addr_s[1] = 32'h0C; wdat_s[1] = 32'h3333_3333;
        @(posedge clk);
        #1 stb_s[1] = 1'b0;
        @(negedge clk);
        check("pre_rst_stall", 32'(stall_s[1]), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_ack",   32'(ack_s[1]),   32'd0);
        check("rst_stall", 32'(stall_s[1]), 32'd0);
        check("rst_data",  rdat_s[1],       32'd0);
        check("rst_reg3",  reg_of(1, 3),    32'd0);
        check("rst_w0_reg3", reg_of(2, 3),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ack_s[1]) acks++;
        end
        check("rst_no_ack", 32'(acks),    32'd0);
        check("rst_reg3_after", reg_of(1, 3), 32'd0);
        cyc_s[1] = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_reg_slave.md
WB_REG_SLAVE -- requirements
Module: wb_reg_slave

Interface
REQ-001 Parameter NREGS, default 16: number of 32-bit registers; power of two, 4..256.
REQ-002 Parameter WAIT_CYCLES, default 1: wait states inserted before ack, 0..15.
REQ-003 Parameter ID_VALUE, default 32'hCAFE_0001: constant returned by register 0.
REQ-004 Port clk, input, 1: single clock; all state on rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port i_wb_cyc, input, 1: bus cycle active from master.
REQ-007 Port i_wb_stb, input, 1: request strobe.
REQ-008 Port i_wb_we, input, 1: write enable (1=write, 0=read).
REQ-009 Port i_wb_addr, input, 32: byte address; bits [1:0] ignored.
REQ-010 Port i_wb_data, input, 32: write data from master.
REQ-011 Port o_wb_data, output, 32: read data; board-level tristate merge is outside this block.
REQ-012 Port o_wb_stall, output, 1: slave busy, request not accepted.
REQ-013 Port o_wb_ack, output, 1: one-cycle transfer completion.
REQ-014 Port o_regs, output, NREGS*32: flattened current register contents, reg k at [32k+:32].

Function
REQ-015 FSM states IDLE, WAIT, ACK; o_wb_stall = 0 only in IDLE.
REQ-016 IDLE: i_wb_cyc && i_wb_stb accepts request; latch address, we, data; next WAIT if WAIT_CYCLES>0, else ACK.
REQ-017 WAIT: down-counter loaded with WAIT_CYCLES-1 at accept; ACK when counter is 0.
REQ-018 ACK: o_wb_ack=1 for exactly one cycle, then IDLE; new request accepted no earlier than the cycle after ACK.
REQ-019 Latency: ack asserted exactly WAIT_CYCLES+1 cycles after the accept cycle.
REQ-020 Index = addr[2 +: log2(NREGS)]; address in range only if addr[31:2+log2(NREGS)] == 0.
REQ-021 Writes commit on the edge entering ACK; read data registered on same edge, held on o_wb_data during ACK, 0 otherwise.
REQ-022 Register 0: read-only, returns ID_VALUE; writes ignored but acked.
REQ-023 Register NREGS-1: read-only transaction counter, +1 per ack (read or write), wraps 32'hFFFF_FFFF -> 0.
REQ-024 Reads of NREGS-1 return counter value before the current transaction's increment.
REQ-025 Registers 1..NREGS-2: read/write, full 32-bit.
REQ-026 i_wb_cyc low in WAIT or ACK: abort to IDLE next cycle, no ack, no write commit, counter unchanged.
REQ-027 i_wb_stb while stalled: ignored, not queued.

Reset
REQ-028 rst high: state IDLE, counter 0, all R/W registers 0, o_wb_ack 0, o_wb_stall 0, o_wb_data 0, immediately (async).
REQ-029 rst mid-transaction: transaction dropped, no ack after release.

Configuration
REQ-030 Macro WB_SLAVE_ERR_EN: adds port o_wb_err, output, 1; out-of-range address -> o_wb_err=1 in place of o_wb_ack, same latency, no write, counter unchanged.
REQ-031 Without WB_SLAVE_ERR_EN: no o_wb_err port; out-of-range access acked normally, reads return 0, writes dropped, counter increments.

Structure
REQ-032 Package wb_slave_pkg: FSM state enum, ID_VALUE default, data width constant 32, WAIT counter width.
REQ-033 Sub-module wb_reg_bank: register array, write port, read mux, counter, o_regs; wb_reg_slave holds FSM and decode.

Verification
REQ-034 W=1, write 32'h1234_5678 to addr 0x04, then read 0x04 -> ack 2 cycles after each accept; read data 32'h1234_5678; counter = 2.
REQ-035 Read addr 0x00 after writing 32'hFFFF_FFFF to 0x00 -> data 32'hCAFE_0001.
REQ-036 W=3, write 0x08, drop i_wb_cyc 2 cycles after accept -> no ack, reg 2 stays 0, counter 0.
REQ-037 Address 0x40 (NREGS=16) -> with WB_SLAVE_ERR_EN: err pulse, no ack; without: ack, data 0.
REQ-038 W=0, back-to-back stb held high -> accepts every 2nd cycle, stall high in ACK cycle, 4 acks in 8 cycles.
REQ-039 Assert rst during WAIT of write to 0x0C -> outputs 0 immediately, reg 3 = 0, no ack after release.
